// File: rtl/match_stick_pkg.sv
// Shared types and display constants for the match-stick game engine.
package match_stick_pkg;

  typedef enum logic [1:0] {
    PLAY = 2'd0,
    ERR  = 2'd1,
    OVER = 2'd2
  } state_t;

  localparam logic [3:0] ERR_NIB  = 4'hE;
  localparam logic [3:0] OVER_NIB = 4'hF;

endpackage

// File: rtl/match_stick_game_ctrl_bcd.sv
// Combinational double-dabble: W-bit binary (0..999) to three BCD digits.
module bin_to_bcd3 #(
  parameter int W = 7
) (
  input  logic [W-1:0] i_bin,
  output logic [3:0]   o_hund,
  output logic [3:0]   o_tens,
  output logic [3:0]   o_units
);

  logic [W+11:0] w_sh;

  always_comb begin
    w_sh = '0;
    w_sh[W-1:0] = i_bin;
    for (int i = 0; i < W; i++) begin
      if (w_sh[W+3:W] > 4'd4)
        w_sh[W+3:W] = w_sh[W+3:W] + 4'd3;
      if (w_sh[W+7:W+4] > 4'd4)
        w_sh[W+7:W+4] = w_sh[W+7:W+4] + 4'd3;
      if (w_sh[W+11:W+8] > 4'd4)
        w_sh[W+11:W+8] = w_sh[W+11:W+8] + 4'd3;
      w_sh = w_sh << 1;
    end
  end

  assign o_hund  = w_sh[W+11:W+8];
  assign o_tens  = w_sh[W+7:W+4];
  assign o_units = w_sh[W+3:W];

endmodule

// File: rtl/match_stick_game_ctrl.sv
// N-player match-stick game engine with move checking,
// winner detection, button edge detection and BCD display word.
module match_stick_game_ctrl
  import match_stick_pkg::*;
#(
  parameter int NUM_PLAYERS  = 2,
  parameter int START_STICKS = 100,
  parameter int MAX_TAKE     = 10,
  parameter int STICK_W      = $clog2(START_STICKS + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         take_i,
  input  logic               btn_take,
  input  logic               btn_new,
  output logic [15:0]        disp_data,
  output logic [3:0]         player_o,
  output logic [STICK_W-1:0] sticks_o,
  output logic               invalid_move,
  output logic               game_over,
  output logic [3:0]         winner
);

  localparam int CW = (STICK_W > 4) ? STICK_W : 4;
  localparam logic [3:0] LAST_P = 4'(NUM_PLAYERS);
  localparam logic [3:0] MAX_T  = 4'(MAX_TAKE);
  localparam logic [STICK_W-1:0] INIT = STICK_W'(START_STICKS);

  state_t             r_state, w_state_nxt;
  logic [STICK_W-1:0] r_sticks, w_sticks_nxt;
  logic [3:0]         r_player, w_player_nxt;
  logic [3:0]         r_winner, w_winner_nxt;
  logic               r_prev_take, r_prev_new;

  logic          w_take_evt, w_new_evt, w_legal;
  logic [CW-1:0] w_take_ext, w_stk_ext, w_rem;
  logic [3:0]    w_next_p;
  logic [3:0]    w_hund, w_tens, w_units;

  assign w_take_evt = btn_take & ~r_prev_take;
  assign w_new_evt  = btn_new & ~r_prev_new;
  assign w_take_ext = CW'(take_i);
  assign w_stk_ext  = CW'(r_sticks);
  assign w_rem      = w_stk_ext - w_take_ext;
  assign w_legal    = (take_i != 4'd0) && (take_i <= MAX_T)
                   && (w_take_ext <= w_stk_ext);
  assign w_next_p   = (r_player == LAST_P) ? 4'd1 : r_player + 4'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= PLAY;
      r_sticks    <= INIT;
      r_player    <= 4'd1;
      r_winner    <= 4'd0;
      r_prev_take <= 1'b0;
      r_prev_new  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_sticks    <= w_sticks_nxt;
      r_player    <= w_player_nxt;
      r_winner    <= w_winner_nxt;
      r_prev_take <= btn_take;
      r_prev_new  <= btn_new;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_sticks_nxt = r_sticks;
    w_player_nxt = r_player;
    w_winner_nxt = r_winner;
    if (w_new_evt) begin
      w_state_nxt  = PLAY;
      w_sticks_nxt = INIT;
      w_player_nxt = 4'd1;
      w_winner_nxt = 4'd0;
    end else if (w_take_evt && r_state != OVER) begin
      if (w_legal) begin
        w_sticks_nxt = w_rem[STICK_W-1:0];
        // Whoever takes the last stick loses.
        if (w_rem == '0) begin
          w_state_nxt  = OVER;
          w_winner_nxt = w_next_p;
        end else begin
          w_state_nxt  = PLAY;
          w_player_nxt = w_next_p;
        end
      end else begin
        w_state_nxt = ERR;
      end
    end
  end

  bin_to_bcd3 #(.W(STICK_W)) u_bcd (
    .i_bin   (r_sticks),
    .o_hund  (w_hund),
    .o_tens  (w_tens),
    .o_units (w_units)
  );

  always_comb begin
    disp_data = {r_player, w_hund, w_tens, w_units};
    unique case (1'b1)
      (r_state == ERR):
        disp_data = {r_player, ERR_NIB, ERR_NIB, ERR_NIB};
      (r_state == OVER):
        disp_data = {r_winner, OVER_NIB, OVER_NIB, OVER_NIB};
      default: ;
    endcase
  end

  assign player_o     = r_player;
  assign sticks_o     = r_sticks;
  assign invalid_move = (r_state == ERR);
  assign game_over    = (r_state == OVER);
  assign winner       = r_winner;

endmodule

// File: tb/tb_match_stick_game_ctrl.sv
// Self-checking bench: vector table plus hand sequences,
// expectations queued at drive time and popped after each edge.
module tb_match_stick_game_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, btn_take, btn_new;
  logic [3:0] take_i;

  always #5 clk = ~clk;

  logic [15:0] disp_a, disp_b;
  logic [3:0]  pl_a, pl_b, win_a, win_b;
  logic [6:0]  stk_a;
  logic [3:0]  stk_b;
  logic        inv_a, inv_b, ovr_a, ovr_b;

  match_stick_game_ctrl u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .take_i       (take_i),
    .btn_take     (btn_take),
    .btn_new      (btn_new),
    .disp_data    (disp_a),
    .player_o     (pl_a),
    .sticks_o     (stk_a),
    .invalid_move (inv_a),
    .game_over    (ovr_a),
    .winner       (win_a)
  );

  match_stick_game_ctrl #(
    .NUM_PLAYERS  (3),
    .START_STICKS (12),
    .MAX_TAKE     (3)
  ) u_dut3 (
    .clk          (clk),
    .rst_n        (rst_n),
    .take_i       (take_i),
    .btn_take     (btn_take),
    .btn_new      (btn_new),
    .disp_data    (disp_b),
    .player_o     (pl_b),
    .sticks_o     (stk_b),
    .invalid_move (inv_b),
    .game_over    (ovr_b),
    .winner       (win_b)
  );

  typedef struct packed {
    logic [15:0] disp;
    logic [3:0]  player;
    logic [9:0]  sticks;
    logic        inv;
    logic        over;
    logic [3:0]  win;
  } obs_t;

  typedef struct {
    string nm;
    obs_t  exp;
    obs_t  mask;
    bit    sel_b;
  } sb_t;

  typedef struct {
    logic [3:0] take;
    obs_t       exp;
  } vec_t;

  obs_t obs_a, obs_b;
  assign obs_a = {disp_a, pl_a, 10'(stk_a), inv_a, ovr_a, win_a};
  assign obs_b = {disp_b, pl_b, 10'(stk_b), inv_b, ovr_b, win_b};

  sb_t  q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  obs_t FULL, NOPL;

  function automatic obs_t mk(logic [15:0] d, logic [3:0] p, int s,
                              logic i, logic o, logic [3:0] w);
    mk = {d, p, 10'(s), i, o, w};
  endfunction

  function automatic logic [15:0] pdisp(logic [3:0] p, int s);
    pdisp = {p, 4'(s / 100), 4'((s / 10) % 10), 4'(s % 10)};
  endfunction

  task automatic step(string nm, logic [3:0] t, logic bt, logic bn,
                      logic rs, obs_t e, obs_t m, bit b);
    sb_t  s;
    obs_t a;
    @(negedge clk);
    take_i   = t;
    btn_take = bt;
    btn_new  = bn;
    rst_n    = rs;
    q.push_back('{nm, e, m, b});
    @(posedge clk);
    #1;
    s = q.pop_front();
    a = s.sel_b ? obs_b : obs_a;
    n_cmp++;
    if ((a & s.mask) !== (s.exp & s.mask)) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (mask %h)",
               s.nm, a, s.exp, s.mask);
    end
  endtask

  // Press then release; state must hold through the release cycle.
  task automatic press(string nm, logic [3:0] t, obs_t e, obs_t m, bit b);
    step(nm, t, 1'b1, 1'b0, 1'b1, e, m, b);
    step({nm, "_rel"}, t, 1'b0, 1'b0, 1'b1, e, m, b);
  endtask

  vec_t tbl[7];
  int   s_m;
  logic [3:0] p_m;

  initial begin
    FULL = '1;
    NOPL = '1;
    NOPL.player = 4'd0;
    rst_n = 1'b0; btn_take = 1'b0; btn_new = 1'b0; take_i = 4'd0;

    tbl[0] = '{4'd0,  mk(16'h1EEE, 1, 100, 1, 0, 0)};
    tbl[1] = '{4'd11, mk(16'h1EEE, 1, 100, 1, 0, 0)};
    tbl[2] = '{4'd3,  mk(16'h2097, 2, 97, 0, 0, 0)};
    tbl[3] = '{4'd7,  mk(16'h1090, 1, 90, 0, 0, 0)};
    tbl[4] = '{4'd10, mk(16'h2080, 2, 80, 0, 0, 0)};
    tbl[5] = '{4'd15, mk(16'h2EEE, 2, 80, 1, 0, 0)};
    tbl[6] = '{4'd10, mk(16'h1070, 1, 70, 0, 0, 0)};

    step("rst_a", 0, 0, 0, 0, mk(16'h1100, 1, 100, 0, 0, 0), FULL, 0);
    step("rst_b", 0, 0, 0, 0, mk(16'h1012, 1, 12, 0, 0, 0), FULL, 1);
    press("take7", 7, mk(16'h2093, 2, 93, 0, 0, 0), FULL, 0);

    step("new1", 0, 0, 1, 1, mk(16'h1100, 1, 100, 0, 0, 0), FULL, 0);
    step("new1_rel", 0, 0, 0, 1, mk(16'h1100, 1, 100, 0, 0, 0), FULL, 0);
    for (int i = 0; i < 7; i++)
      press($sformatf("tbl%0d", i), tbl[i].take, tbl[i].exp, FULL, 0);

    for (int i = 0; i < 50; i++)
      step("hold", 1, 1, 0, 1, mk(16'h2069, 2, 69, 0, 0, 0), FULL, 0);
    step("hold_rel", 1, 0, 0, 1, mk(16'h2069, 2, 69, 0, 0, 0), FULL, 0);

    step("new2", 0, 0, 1, 1, mk(16'h1100, 1, 100, 0, 0, 0), FULL, 0);
    step("new2_rel", 0, 0, 0, 1, mk(16'h1100, 1, 100, 0, 0, 0), FULL, 0);
    s_m = 100;
    p_m = 4'd1;
    for (int i = 0; i < 11; i++) begin
      logic [3:0] t;
      t = (i < 9) ? 4'd10 : 4'd3;
      s_m = s_m - int'(t);
      p_m = (p_m == 4'd2) ? 4'd1 : 4'd2;
      press($sformatf("run%0d", i), t,
            mk(pdisp(p_m, s_m), p_m, s_m, 0, 0, 0), FULL, 0);
    end
    press("over_err", 5, mk(16'h2EEE, 2, 4, 1, 0, 0), FULL, 0);
    press("over_win", 4, mk(16'h1FFF, 0, 0, 0, 1, 1), NOPL, 0);
    press("over_ign1", 1, mk(16'h1FFF, 0, 0, 0, 1, 1), NOPL, 0);
    press("over_ign2", 3, mk(16'h1FFF, 0, 0, 0, 1, 1), NOPL, 0);

    step("new3", 0, 0, 1, 1, mk(16'h1100, 1, 100, 0, 0, 0), FULL, 0);
    step("new3_rel", 0, 0, 0, 1, mk(16'h1100, 1, 100, 0, 0, 0), FULL, 0);
    press("mid7", 7, mk(16'h2093, 2, 93, 0, 0, 0), FULL, 0);
    step("both", 5, 1, 1, 1, mk(16'h1100, 1, 100, 0, 0, 0), FULL, 0);
    step("both_rel", 5, 0, 0, 1, mk(16'h1100, 1, 100, 0, 0, 0), FULL, 0);

    press("pre_err", 0, mk(16'h1EEE, 1, 100, 1, 0, 0), FULL, 0);
    step("rst_err", 5, 1, 0, 0, mk(16'h1100, 1, 100, 0, 0, 0), FULL, 0);
    step("post_rst", 5, 0, 0, 1, mk(16'h1100, 1, 100, 0, 0, 0), FULL, 0);

    step("rst3", 0, 0, 0, 0, mk(16'h1012, 1, 12, 0, 0, 0), FULL, 1);
    press("p3_a", 3, mk(16'h2009, 2, 9, 0, 0, 0), FULL, 1);
    press("p3_b", 3, mk(16'h3006, 3, 6, 0, 0, 0), FULL, 1);
    press("p3_c", 3, mk(16'h1003, 1, 3, 0, 0, 0), FULL, 1);
    press("p3_big", 4, mk(16'h1EEE, 1, 3, 1, 0, 0), FULL, 1);
    press("p3_d", 3, mk(16'h2FFF, 0, 0, 0, 1, 2), NOPL, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/match_stick_game_ctrl.md
Name: match_stick_game_ctrl

Overview:
Parametrised N-player match-stick game engine. It is the successor to the fixed 2-player / 100-stick controller, adding legal-move checking against remaining sticks, game-over and winner detection, button edge detection, and BCD display formatting. It sits between the dip-switch/push-button inputs and the existing 4-digit seven-segment multiplexer. It drives that multiplexer's 16-bit data word directly.

Parameters:
NUM_PLAYERS, 2, number of players; legal range 2..15; players are numbered 1..NUM_PLAYERS.
START_STICKS, 100, sticks at the start of each game; legal range 1..999.
MAX_TAKE, 10, largest legal take per move; legal range 1..15.
STICK_W, $clog2(START_STICKS+1), width of the stick counter (derived; do not override).

Ports:
clk  in  1  system clock; all logic on its rising edge
rst_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk
take_i  in  4  requested take from the dip switches, unsigned
btn_take  in  1  commit-move push button, level, already synchronised
btn_new  in  1  new-game push button, level, already synchronised
disp_data  out  16  display word {nibble3, nibble2, nibble1, nibble0} for the seven-segment driver
player_o  out  4  current player, 1-based
sticks_o  out  STICK_W  remaining sticks, binary
invalid_move  out  1  high while in the ERR state
game_over  out  1  high while in the OVER state
winner  out  4  winning player while game_over is high; 0 otherwise

Behaviour:
- Edge detection: registered copies of btn_take and btn_new.
  - take_evt = btn_take & ~prev_take; new_evt = btn_new & ~prev_new.
  - Holding a button produces exactly one event.
- Reset (rst_n=0 at an edge): state=PLAY, sticks=START_STICKS, player=1, invalid_move=0, game_over=0, winner=0, both prev registers=0.
- Legal move: 1 <= take_i <= MAX_TAKE and take_i <= sticks. All comparisons are unsigned.
- States:
  - PLAY:
    - take_evt with a legal move: sticks <= sticks - take_i.
      - If the result is 0, go to OVER with winner = next player (the taker of the last stick loses).
      - Otherwise player <= next player and stay in PLAY.
    - take_evt with an illegal move: go to ERR; sticks and player unchanged.
  - ERR: invalid_move=1. take_evt re-evaluates the current take_i with the PLAY rules, clears invalid_move, and goes to PLAY or OVER.
  - OVER: game_over=1. take_evt is ignored.
  - Any state: new_evt → PLAY, sticks=START_STICKS, player=1, flags cleared, winner=0.
- Next player: player+1, wrapping from NUM_PLAYERS to 1.
- Simultaneous events: new_evt has priority over take_evt. rst_n has priority over both.
- Latency: if a button is first sampled high at edge n, the event is detected at edge n. All register and output updates are visible after edge n.
- All outputs are registered state or combinational decode of registered state only; there are no input-to-output combinational paths.
- disp_data:
  - PLAY: {player, BCD hundreds, tens, units of sticks}.
  - ERR: {player, 4'hE, 4'hE, 4'hE}.
  - OVER: {winner, 4'hF, 4'hF, 4'hF}.
- The underflow guard (take_i <= sticks) guarantees the counter never wraps.

Decomposition:
- Package match_stick_pkg:
  - state enum: PLAY, ERR, OVER (2-bit);
  - display nibble constants: ERR_NIB = 4'hE, OVER_NIB = 4'hF.
- Sub-module bin_to_bcd3: combinational double-dabble, STICK_W-bit binary to three BCD digits. Values are 0..999 by construction.

Test Plan:
- Reset, defaults → disp_data=16'h1100, sticks_o=100, player_o=1. take_i=7 with one btn_take press → disp_data=16'h2093, player_o=2.
- take_i=0, then take_i=11 → each press gives invalid_move=1 and disp_data=16'h1EEE with sticks unchanged. take_i=3 with a press → invalid_move=0, disp_data=16'h2097.
- Button held for 50 cycles with take_i=1 → exactly one decrement, 100→99.
- sticks=4, player 2, take_i=5 → ERR. take_i=4 with a press → game_over=1, winner=1, disp_data=16'h1FFF. Further btn_take presses → no change.
- btn_new and btn_take rising in the same cycle mid-game → fresh game: 16'h1100, no decrement.
- NUM_PLAYERS=3, START_STICKS=12, MAX_TAKE=3; take 3,3,3,3 → players 1→2→3→1. Player 1 takes the last sticks → winner=2, disp_data=16'h2FFF.
- rst_n=0 asserted for one cycle mid-ERR → PLAY defaults restored on the next cycle.
